// File: rtl/branch_cond_ctrl.sv
//------------------------------------------------------------------------------
// branch_cond_ctrl
//
// Resolves conditional branches around an external 8:1 flag multiplexer.
// The block holds the architectural flag register. It accepts one branch
// request at a time and drives the mux with a snapshot of the flags and the
// condition select. It waits MUX_LAT cycles for the mux result, applies the
// condition polarity, and then reports the outcome for one cycle. When the
// branch is taken it also pulses a PC load.
//
// Ports
//   clk         system clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   alu_flags   flag values from the ALU
//   flags_we    write alu_flags into the flag register this edge
//   br_valid    branch request present (held by requester until accepted)
//   br_cond     [2:0] condition select, [3] invert result
//   br_target   branch destination
//   br_ready    controller can accept a request (state decode)
//   mux_flags   flag vector driven to the flag mux
//   mux_select  select driven to the flag mux
//   mux_flag    selected flag returned by the mux
//   pc_load     one-cycle pulse: load pc_target into the PC
//   pc_target   latched branch target
//   br_done     one-cycle pulse: branch resolved
//   br_taken    resolution result, valid while br_done=1
//------------------------------------------------------------------------------
module branch_cond_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int MUX_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        alu_flags,
    input  logic              flags_we,
    input  logic              br_valid,
    input  logic [3:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_ready,
    output logic [5:0]        mux_flags,
    output logic [2:0]        mux_select,
    input  logic              mux_flag,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              br_done,
    output logic              br_taken
);

    localparam int CNT_W = (MUX_LAT < 2) ? 1 : $clog2(MUX_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q,    state_d;
    logic [5:0]          flags_q,    flags_d;
    logic [5:0]          snap_q,     snap_d;
    logic [3:0]          cond_q,     cond_d;
    logic [ADDR_W-1:0]   target_q,   target_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                pc_load_q,  pc_load_d;
    logic                br_done_q,  br_done_d;
    logic                br_taken_q, br_taken_d;

    // Outcome of the fixed codes 6 (always) and 7 (never).
    logic                fixed_taken;
    assign fixed_taken = (br_cond[2:0] == 3'd6) ^ br_cond[3];

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            flags_q    <= '0;
            snap_q     <= '0;
            cond_q     <= '0;
            target_q   <= '0;
            cnt_q      <= '0;
            pc_load_q  <= 1'b0;
            br_done_q  <= 1'b0;
            br_taken_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            snap_q     <= snap_d;
            cond_q     <= cond_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            pc_load_q  <= pc_load_d;
            br_done_q  <= br_done_d;
            br_taken_q <= br_taken_d;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        flags_d    = flags_we ? alu_flags : flags_q;
        snap_d     = snap_q;
        cond_d     = cond_q;
        target_d   = target_q;
        cnt_d      = cnt_q;
        // The result pulses are high only in the cycle spent in DONE.
        pc_load_d  = 1'b0;
        br_done_d  = 1'b0;
        br_taken_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (br_valid) begin
                    cond_d   = br_cond;
                    target_d = br_target;
                    // A flag write on the accept edge is forwarded into the
                    // snapshot so the branch sees the newest flags.
                    snap_d   = flags_we ? alu_flags : flags_q;
                    cnt_d    = CNT_W'(MUX_LAT);
                    if (br_cond[2:1] == 2'b11) begin
                        // Codes 6/7 do not need the mux.
                        state_d    = S_DONE;
                        br_done_d  = 1'b1;
                        br_taken_d = fixed_taken;
                        pc_load_d  = fixed_taken;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = S_DONE;
                    br_done_d  = 1'b1;
                    br_taken_d = mux_flag ^ cond_q[3];
                    pc_load_d  = mux_flag ^ cond_q[3];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    // While idle, the mux shows the live flag register. During a request it
    // shows the snapshot and the condition, and both stay constant.
    assign mux_flags  = (state_q == S_IDLE) ? flags_q : snap_q;
    assign mux_select = (state_q == S_IDLE) ? 3'd0    : cond_q[2:0];

    // br_ready is held low during reset. It is never derived from br_valid.
    assign br_ready   = (state_q == S_IDLE) && rst_n;

    assign pc_load    = pc_load_q;
    assign br_done    = br_done_q;
    assign br_taken   = br_taken_q;
    assign pc_target  = target_q;

endmodule

// File: tb/tb_branch_cond_ctrl.sv
module tb_branch_cond_ctrl;

    localparam int ADDR_W  = 8;
    localparam int MUX_LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [5:0]        alu_flags;
    logic              flags_we;
    logic              br_valid;
    logic [3:0]        br_cond;
    logic [ADDR_W-1:0] br_target;
    logic              br_ready;
    logic [5:0]        mux_flags;
    logic [2:0]        mux_select;
    logic              mux_flag;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic              br_done;
    logic              br_taken;

    logic              junk_bit = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Architectural flag register as the bench believes it to be.
    logic [5:0] flags_m;

    branch_cond_ctrl #(.ADDR_W(ADDR_W), .MUX_LAT(MUX_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_flags  (alu_flags),
        .flags_we   (flags_we),
        .br_valid   (br_valid),
        .br_cond    (br_cond),
        .br_target  (br_target),
        .br_ready   (br_ready),
        .mux_flags  (mux_flags),
        .mux_select (mux_select),
        .mux_flag   (mux_flag),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .br_done    (br_done),
        .br_taken   (br_taken)
    );

    always #5 clk = ~clk;

    // External 8:1 flag mux. Inputs 6 and 7 carry noise that must be ignored.
    always @(negedge clk) junk_bit <= 1'($urandom);
    assign mux_flag = (mux_select < 3'd6) ? mux_flags[mux_select] : junk_bit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference outcome from the condition rules.
    function automatic bit ref_taken(input logic [3:0] c, input logic [5:0] f);
        bit raw;
        if (c[2:0] < 3'd6) raw = f[c[2:0]];
        else               raw = (c[2:0] == 3'd6);
        return raw ^ c[3];
    endfunction

    task automatic write_flags(input logic [5:0] v);
        flags_we  = 1'b1;
        alu_flags = v;
        tick();
        flags_we  = 1'b0;
        flags_m   = v;
        chk("idle_mux_flags", 32'(mux_flags), 32'(flags_m));
        chk("idle_mux_sel", 32'(mux_select), 32'd0);
    endtask

    // One complete branch. The task is called at a sample point while the
    // controller is idle.
    task automatic branch(input logic [3:0] c, input logic [7:0] tgt,
                          input bit fwd, input logic [5:0] fv, input bit wr_wait);
        logic [5:0] snap;
        bit         exp_t;
        bit         ww;
        int         n;
        ww   = wr_wait && (c[2:0] < 3'd6);
        snap = fwd ? fv : flags_m;
        chk("ready_idle", 32'(br_ready), 32'd1);
        br_valid  = 1'b1;
        br_cond   = c;
        br_target = tgt;
        if (fwd) begin
            flags_we  = 1'b1;
            alu_flags = fv;
        end
        tick();
        if (fwd) flags_m = fv;
        br_valid = 1'b0;
        flags_we = 1'b0;
        exp_t = ref_taken(c, snap);
        chk("ready_busy", 32'(br_ready), 32'd0);
        chk("mux_sel", 32'(mux_select), 32'(c[2:0]));
        chk("mux_flags", 32'(mux_flags), 32'(snap));
        if (ww) begin
            flags_we  = 1'b1;
            alu_flags = ~snap;
        end
        n = 0;
        while (br_done !== 1'b1 && n < 10) begin
            tick();
            n++;
            if (ww && n == 1) begin
                flags_we = 1'b0;
                flags_m  = ~snap;
            end
        end
        chk("latency", 32'(n), (c[2:0] < 3'd6) ? 32'(MUX_LAT) : 32'd0);
        chk("br_done", 32'(br_done), 32'd1);
        chk("br_taken", 32'(br_taken), 32'(exp_t));
        chk("pc_load", 32'(pc_load), 32'(exp_t));
        chk("pc_target", 32'(pc_target), 32'(tgt));
        chk("done_ready", 32'(br_ready), 32'd0);
        if (ww) chk("snap_hold", 32'(mux_flags), 32'(snap));
        tick();
        chk("done_clear", 32'(br_done), 32'd0);
        chk("pc_clear", 32'(pc_load), 32'd0);
        chk("ready_back", 32'(br_ready), 32'd1);
        chk("target_hold", 32'(pc_target), 32'(tgt));
        chk("flags_after", 32'(mux_flags), 32'(flags_m));
        $display("txn cond=%h target=%h snap=%b exp_taken=%0d got_taken=%0d lat=%0d",
                 c, tgt, snap, exp_t, br_taken, n);
    endtask

    initial begin
        int  first_ready;
        bool_dummy_init();
        rst_n     = 1'b0;
        alu_flags = '0;
        flags_we  = 1'b0;
        br_valid  = 1'b0;
        br_cond   = '0;
        br_target = '0;
        flags_m   = '0;
        tick();
        tick();
        chk("rst_pc_load", 32'(pc_load), 32'd0);
        chk("rst_br_done", 32'(br_done), 32'd0);
        chk("rst_br_taken", 32'(br_taken), 32'd0);
        chk("rst_target", 32'(pc_target), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(br_ready), 32'd1);
        chk("rst_mux_flags", 32'(mux_flags), 32'd0);
        chk("rst_mux_sel", 32'(mux_select), 32'd0);

        // Basic taken and not-taken cases, including inversion.
        write_flags(6'b010010);
        branch(4'h1, 8'h3C, 1'b0, 6'd0, 1'b0);
        branch(4'h0, 8'h11, 1'b0, 6'd0, 1'b0);
        branch(4'h8, 8'h22, 1'b0, 6'd0, 1'b0);

        // Sweep all codes, both polarities.
        for (int c = 0; c < 16; c++) begin
            branch(4'(c), 8'(8'h40 + c), 1'b0, 6'd0, 1'b0);
        end

        // A flag write on the accept edge is forwarded. A write during WAIT
        // leaves the snapshot alone.
        branch(4'h0, 8'h55, 1'b1, 6'b000001, 1'b0);
        branch(4'h0, 8'h56, 1'b0, 6'd0, 1'b1);
        branch(4'h3, 8'h57, 1'b0, 6'd0, 1'b1);

        // br_valid held high: the next accept happens only after DONE.
        br_valid  = 1'b1;
        br_cond   = 4'h2;
        br_target = 8'h99;
        first_ready = -1;
        for (int k = 1; k <= MUX_LAT + 2; k++) begin
            tick();
            if (br_ready === 1'b1 && first_ready < 0) first_ready = k;
        end
        chk("b2b_spacing", 32'(first_ready), 32'(MUX_LAT + 2));
        tick();
        br_valid = 1'b0;
        chk("b2b_second_accept", 32'(br_ready), 32'd0);
        for (int k = 0; k < 10 && br_ready !== 1'b1; k++) tick();
        chk("b2b_drain", 32'(br_ready), 32'd1);
        $display("txn back_to_back spacing=%0d", first_ready);

        // Reset in WAIT aborts the branch without a pulse.
        write_flags(6'b111111);
        br_valid  = 1'b1;
        br_cond   = 4'h5;
        br_target = 8'hA5;
        tick();
        br_valid = 1'b0;
        chk("abort_in_wait", 32'(br_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_pc_load", 32'(pc_load), 32'd0);
        chk("abort_br_done", 32'(br_done), 32'd0);
        chk("abort_target", 32'(pc_target), 32'd0);
        chk("abort_mux_flags", 32'(mux_flags), 32'd0);
        chk("abort_mux_sel", 32'(mux_select), 32'd0);
        tick();
        rst_n   = 1'b1;
        flags_m = '0;
        begin
            bit seen_pulse;
            seen_pulse = 1'b0;
            for (int k = 0; k < 4; k++) begin
                tick();
                if (pc_load === 1'b1 || br_done === 1'b1) seen_pulse = 1'b1;
            end
            chk("abort_no_pulse", 32'(seen_pulse), 32'd0);
        end
        chk("abort_ready", 32'(br_ready), 32'd1);
        $display("txn reset_abort done");

        // Randomized branches against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [3:0] rc;
            logic [7:0] rt;
            logic [5:0] rf;
            bit         rfwd;
            bit         rww;
            rc   = 4'($urandom);
            rt   = 8'($urandom);
            rf   = 6'($urandom);
            rfwd = 1'($urandom);
            rww  = 1'($urandom);
            if ($urandom_range(0, 2) == 0) write_flags(6'($urandom));
            branch(rc, rt, rfwd, rf, rww);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic bool_dummy_init();
        junk_bit = 1'b0;
    endtask

    // Safety net against a hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
